// File: rtl/spi_xfer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_sched
//  Purpose  : Round-robin scheduler sharing one spi_top SPI master among
//             NREQ requesters. Acts as the only Wishbone master on the core:
//             programs TX_0/SS/CTRL, polls busy, reads RX_0 and returns it.
//  Revision : 1.0  initial release
// ============================================================================
module spi_xfer_sched #(
    parameter int          NREQ     = 4,
    parameter logic [31:0] DIVIDER  = 32'h0000_0001,
    parameter logic [15:0] POLL_MAX = 16'd4096
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*32-1:0]   req_txd_i,
    input  logic [NREQ*5-1:0]    req_len_i,
    input  logic [NREQ*3-1:0]    req_ss_i,
    input  logic [NREQ*3-1:0]    req_mode_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [31:0]          rdata_o,
    output logic [4:0]           m_adr_o,
    output logic [31:0]          m_dat_o,
    input  logic [31:0]          m_dat_i,
    output logic                 m_we_o,
    output logic                 m_stb_o,
    output logic                 m_cyc_o,
    output logic [3:0]           m_sel_o,
    input  logic                 m_ack_i,
    input  logic                 m_err_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // spi_top register map
    localparam logic [4:0] ADR_DATA = 5'h00;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_DIV  = 5'h14;
    localparam logic [4:0] ADR_SS   = 5'h18;

    // CTRL.GO_BSY bit
    localparam logic [31:0] CTRL_GO = 32'h0000_0100;

    typedef enum logic [3:0] {
        INIT_DIV = 4'd0,
        IDLE     = 4'd1,
        W_TX     = 4'd2,
        W_SS     = 4'd3,
        W_CFG    = 4'd4,
        W_GO     = 4'd5,
        POLL     = 4'd6,
        R_RX     = 4'd7,
        W_SSCLR  = 4'd8,
        FIN      = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers (_q) with their next values (_d)
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [4:0]        adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [31:0]       txd_q, txd_d;
    logic [4:0]        len_q, len_d;
    logic [2:0]        ss_q, ss_d;
    logic [2:0]        mode_q, mode_d;
    logic [15:0]       poll_q, poll_d;
    logic              eflag_q, eflag_d;

    // Arbiter result
    logic              arb_found;
    logic [IW-1:0]     arb_win;
    logic [IW-1:0]     cand;

    // Access decode for the current state
    logic [4:0]        acc_adr;
    logic              acc_we;
    logic [31:0]       acc_dat;

    // Derived configuration words for the latched request
    logic [6:0]        char_len;
    logic [31:0]       cfg_word;
    logic [31:0]       ss_word;

    // A length field of zero selects a full 32-bit character
    assign char_len = (len_q == 5'd0) ? 7'd32 : {2'b00, len_q};
    // {ass=0, ie=0, lsb, tx_neg, rx_neg, go=0, 1'b0, char_len}
    assign cfg_word = {18'b0, 1'b0, 1'b0, mode_q, 1'b0, 1'b0, char_len};
    assign ss_word  = {24'b0, 8'd1 << ss_q};

    // Round-robin search for the first active request after the last winner
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(last_q) + 1 + i) % NREQ);
            if (!arb_found && req_i[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    // Address, direction and write data of the access owned by each state
    always_comb begin
        acc_adr = '0;
        acc_we  = 1'b0;
        acc_dat = '0;
        case (state_q)
            INIT_DIV: begin acc_adr = ADR_DIV;  acc_we = 1'b1; acc_dat = DIVIDER;             end
            W_TX:     begin acc_adr = ADR_DATA; acc_we = 1'b1; acc_dat = txd_q;               end
            W_SS:     begin acc_adr = ADR_SS;   acc_we = 1'b1; acc_dat = ss_word;             end
            W_CFG:    begin acc_adr = ADR_CTRL; acc_we = 1'b1; acc_dat = cfg_word;            end
            W_GO:     begin acc_adr = ADR_CTRL; acc_we = 1'b1; acc_dat = cfg_word | CTRL_GO;  end
            POLL:     begin acc_adr = ADR_CTRL; acc_we = 1'b0;                                end
            R_RX:     begin acc_adr = ADR_DATA; acc_we = 1'b0;                                end
            W_SSCLR:  begin acc_adr = ADR_SS;   acc_we = 1'b1; acc_dat = '0;                  end
            default:  begin acc_adr = '0;       acc_we = 1'b0; acc_dat = '0;                  end
        endcase
    end

    // Next-state and output logic; every bus access state launches one cycle
    // when the bus is idle and advances once that cycle terminates. Because a
    // launch is only possible with cyc low, consecutive cycles are always
    // separated by at least one idle clock.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        last_d  = last_q;
        owner_d = owner_q;
        txd_d   = txd_q;
        len_d   = len_q;
        ss_d    = ss_q;
        mode_d  = mode_q;
        poll_d  = poll_q;
        eflag_d = eflag_q;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d          = W_TX;
                    gnt_d            = '0;
                    gnt_d[arb_win]   = 1'b1;
                    owner_d          = arb_win;
                    txd_d            = req_txd_i[arb_win*32 +: 32];
                    len_d            = req_len_i[arb_win*5 +: 5];
                    ss_d             = req_ss_i[arb_win*3 +: 3];
                    mode_d           = req_mode_i[arb_win*3 +: 3];
                    poll_d           = '0;
                    eflag_d          = 1'b0;
                end
            end

            // Completion pulse, grant release and last-winner update were all
            // registered on entry, so they are visible during this cycle.
            FIN: begin
                state_d = IDLE;
            end

            default: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = acc_we;
                    adr_d = acc_adr;
                    dat_d = acc_dat;
                    sel_d = 4'hf;
                end else if (m_ack_i || m_err_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    adr_d = '0;
                    dat_d = '0;
                    sel_d = '0;
                    if (state_q == INIT_DIV) begin
                        // An errored divider write simply gets retried
                        if (!m_err_i) begin
                            state_d = IDLE;
                        end
                    end else if (state_q == W_SSCLR) begin
                        state_d        = FIN;
                        gnt_d          = '0;
                        last_d         = owner_q;
                        if (eflag_q || m_err_i) begin
                            err_d[owner_q]  = 1'b1;
                        end else begin
                            done_d[owner_q] = 1'b1;
                        end
                    end else if (m_err_i) begin
                        eflag_d = 1'b1;
                        state_d = W_SSCLR;
                    end else begin
                        case (state_q)
                            W_TX:  state_d = W_SS;
                            W_SS:  state_d = W_CFG;
                            W_CFG: state_d = W_GO;
                            W_GO:  state_d = POLL;
                            POLL: begin
                                if (!m_dat_i[8]) begin
                                    state_d = R_RX;
                                end else if (poll_q == POLL_MAX - 16'd1) begin
                                    eflag_d = 1'b1;
                                    state_d = W_SSCLR;
                                end else begin
                                    poll_d  = poll_q + 16'd1;
                                end
                            end
                            R_RX: begin
                                rdata_d = m_dat_i;
                                state_d = W_SSCLR;
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
            end
        endcase
    end

    // State register and registered outputs, cleared asynchronously by reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= INIT_DIV;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            txd_q   <= '0;
            len_q   <= '0;
            ss_q    <= '0;
            mode_q  <= '0;
            poll_q  <= '0;
            eflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            txd_q   <= txd_d;
            len_q   <= len_d;
            ss_q    <= ss_d;
            mode_q  <= mode_d;
            poll_q  <= poll_d;
            eflag_q <= eflag_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
    assign m_we_o  = we_q;
    assign m_stb_o = cyc_q;
    assign m_cyc_o = cyc_q;
    assign m_sel_o = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_sched
//  Purpose  : Self-checking bench for spi_xfer_sched with a behavioural
//             spi_top slave and a bus-access scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_xfer_sched;

    localparam int K_OK    = 0;
    localparam int K_GOERR = 1;
    localparam int K_TMO   = 2;
    localparam int K_ABORT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [127:0]  txd;
    logic [19:0]   len;
    logic [11:0]   ss;
    logic [11:0]   mode;
    logic [3:0]    gnt, done, err;
    logic [31:0]   rdata;
    logic [4:0]    adr;
    logic [31:0]   wdat;
    logic [31:0]   rdat;
    logic          we, stb, cyc;
    logic [3:0]    sel;
    logic          ack, berr;

    typedef struct packed {
        logic [4:0]  adr;
        logic        we;
        logic [31:0] dat;
    } acc_t;

    acc_t exp_q[$];
    acc_t obs_q[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int busy_polls = 0;
    bit stuck      = 1'b0;
    bit err_go     = 1'b0;
    bit multi_hot  = 1'b0;

    logic [31:0] tx_reg;
    int          busy_left;

    // Requester configurations and the register values they must produce
    logic [31:0] txd_c  [4] = '{32'h0000_005a, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    logic [4:0]  len_c  [4] = '{5'd8, 5'd16, 5'd0, 5'd31};
    logic [2:0]  ss_c   [4] = '{3'd0, 3'd1, 3'd5, 3'd7};
    logic [2:0]  mode_c [4] = '{3'b000, 3'b001, 3'b100, 3'b010};
    logic [31:0] ssv_c  [4] = '{32'h01, 32'h02, 32'h20, 32'h80};
    logic [31:0] cfg_c  [4] = '{32'h008, 32'h210, 32'h820, 32'h41f};

    spi_xfer_sched #(
        .NREQ     (4),
        .DIVIDER  (32'h0000_0001),
        .POLL_MAX (16'd8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .req_i      (req),
        .req_txd_i  (txd),
        .req_len_i  (len),
        .req_ss_i   (ss),
        .req_mode_i (mode),
        .gnt_o      (gnt),
        .done_o     (done),
        .err_o      (err),
        .rdata_o    (rdata),
        .m_adr_o    (adr),
        .m_dat_o    (wdat),
        .m_dat_i    (rdat),
        .m_we_o     (we),
        .m_stb_o    (stb),
        .m_cyc_o    (cyc),
        .m_sel_o    (sel),
        .m_ack_i    (ack),
        .m_err_i    (berr)
    );

    always #5 clk = ~clk;

    // spi_top-like slave: acks one cycle after stb, loops RX back as TX^0xff
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            berr      <= 1'b0;
            rdat      <= '0;
            tx_reg    <= '0;
            busy_left <= 0;
        end else begin
            ack  <= 1'b0;
            berr <= 1'b0;
            if (cyc && stb && !ack && !berr) begin
                obs_q.push_back('{adr, we, wdat});
                if (we && adr == 5'h10 && wdat[8] && err_go) begin
                    berr <= 1'b1;
                end else begin
                    ack <= 1'b1;
                    if (we) begin
                        if (adr == 5'h00) tx_reg <= wdat;
                        if (adr == 5'h10 && wdat[8]) busy_left <= busy_polls;
                    end else if (adr == 5'h10) begin
                        rdat <= {23'b0, (stuck || busy_left != 0), 8'h00};
                        if (busy_left != 0) busy_left <= busy_left - 1;
                    end else if (adr == 5'h00) begin
                        rdat <= tx_reg ^ 32'h0000_00ff;
                    end else begin
                        rdat <= '0;
                    end
                end
            end
        end
    end

    // Sticky flag for any multi-hot grant
    always @(negedge clk) begin
        if (!$onehot0(gnt)) multi_hot <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_acc(input logic [4:0] a, input logic w, input logic [31:0] d);
        exp_q.push_back('{a, w, d});
    endtask

    task automatic push_xfer(input int k, input int npolls, input int kind);
        push_acc(5'h00, 1'b1, txd_c[k]);
        push_acc(5'h18, 1'b1, ssv_c[k]);
        push_acc(5'h10, 1'b1, cfg_c[k]);
        push_acc(5'h10, 1'b1, cfg_c[k] | 32'h100);
        if (kind != K_GOERR) begin
            for (int i = 0; i < npolls; i++) push_acc(5'h10, 1'b0, 32'h0);
        end
        if (kind == K_OK) push_acc(5'h00, 1'b0, 32'h0);
        if (kind != K_ABORT) push_acc(5'h18, 1'b1, 32'h0);
    endtask

    // Compare every observed access against the expected sequence
    task automatic drain_bus();
        acc_t o;
        acc_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check("bus_expect_available", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bus_adr", 64'(o.adr), 64'(e.adr));
                check("bus_we", 64'(o.we), 64'(e.we));
                if (e.we) check("bus_wdat", 64'(o.dat), 64'(e.dat));
            end
        end
    endtask

    task automatic wait_init_ack();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (ack || berr) seen = 1'b1;
        end
        check("init_ack_seen", 64'(seen), 64'd1);
        check("no_gnt_before_init", 64'(gnt), 64'd0);
    endtask

    task automatic run_xfer(input int k, input bit exp_err, input logic [3:0] nxt,
                            input logic [31:0] exp_rd, input int exp_cyc);
        bit seen;
        int n;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 4'b0000) seen = 1'b1;
        end
        check("grant_seen", 64'(seen), 64'd1);
        if (!seen) return;
        check("gnt_owner", 64'(gnt), 64'(1 << k));
        req  = nxt;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if ((done | err) != 4'b0000) seen = 1'b1;
        end
        check("finish_seen", 64'(seen), 64'd1);
        check("done_vec", 64'(done), exp_err ? 64'd0 : 64'(1 << k));
        check("err_vec", 64'(err), exp_err ? 64'(1 << k) : 64'd0);
        check("gnt_drop_with_done", 64'(gnt), 64'd0);
        check("rdata", 64'(rdata), 64'(exp_rd));
        if (exp_cyc > 0) check("grant_to_done_cycles", 64'(n), 64'(exp_cyc));
        drain_bus();
        @(negedge clk);
        check("pulse_one_cycle", 64'(done | err), 64'd0);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < 4; k++) begin
            txd[k*32 +: 32] = txd_c[k];
            len[k*5 +: 5]   = len_c[k];
            ss[k*3 +: 3]    = ss_c[k];
            mode[k*3 +: 3]  = mode_c[k];
        end

        // Reset state with requester 0 already asking
        req = 4'b0001;
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_dat", 64'(wdat), 64'd0);

        // Divider init, then the single reference transfer (one poll)
        push_acc(5'h14, 1'b1, 32'h1);
        push_xfer(0, 1, K_OK);
        rst_n = 1'b1;
        wait_init_ack();
        run_xfer(0, 1'b0, 4'b1111, 32'h0000_00a5, 21);

        // Round robin with all requesting; busy for two polls each
        busy_polls = 2;
        push_xfer(1, 3, K_OK);
        run_xfer(1, 1'b0, 4'b1111, 32'h1111_11ee, 0);
        push_xfer(2, 3, K_OK);
        run_xfer(2, 1'b0, 4'b1111, 32'h2222_22dd, 0);
        push_xfer(3, 3, K_OK);
        run_xfer(3, 1'b0, 4'b1111, 32'h3333_33cc, 0);
        push_xfer(0, 3, K_OK);
        run_xfer(0, 1'b0, 4'b0101, 32'h0000_00a5, 0);
        push_xfer(2, 3, K_OK);
        run_xfer(2, 1'b0, 4'b0101, 32'h2222_22dd, 0);
        push_xfer(0, 3, K_OK);
        run_xfer(0, 1'b0, 4'b0000, 32'h0000_00a5, 0);

        // Bus error on the GO write of requester 1; rdata keeps 0xa5
        busy_polls = 0;
        err_go     = 1'b1;
        req        = 4'b0010;
        push_xfer(1, 0, K_GOERR);
        run_xfer(1, 1'b1, 4'b0000, 32'h0000_00a5, 0);
        err_go     = 1'b0;

        // Busy stuck high: exactly POLL_MAX=8 CTRL reads, then timeout
        stuck = 1'b1;
        req   = 4'b0001;
        push_xfer(0, 8, K_TMO);
        run_xfer(0, 1'b1, 4'b0000, 32'h0000_00a5, 0);

        // Reset in the middle of polling for requester 2
        req = 4'b0100;
        push_xfer(2, 1, K_ABORT);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (cyc && adr == 5'h10 && !we) seen = 1'b1;
        end
        check("poll_reached", 64'(seen), 64'd1);
        check("gnt_before_reset", 64'(gnt), 64'b0100);
        req = 4'b0101;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 64'(gnt), 64'd0);
        check("async_rst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
        check("async_rst_adr_dat_sel", 64'({adr, wdat, sel}), 64'd0);
        check("async_rst_rdata", 64'(rdata), 64'd0);
        check("async_rst_done_err", 64'({done, err}), 64'd0);
        drain_bus();
        check("aborted_seq_consumed", 64'(exp_q.size()), 64'd0);

        // After release: divider again, then requester 0 wins first
        stuck = 1'b0;
        push_acc(5'h14, 1'b1, 32'h1);
        push_xfer(0, 1, K_OK);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init_ack();
        run_xfer(0, 1'b0, 4'b0000, 32'h0000_00a5, 21);

        repeat (5) @(negedge clk);
        drain_bus();
        check("all_expected_seen", 64'(exp_q.size()), 64'd0);
        check("gnt_never_multihot", 64'(multi_hot), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
